// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU push port, status and emitter valid/ready handshake of the UART TX FIFO.
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          i_ready;
  modport master (output wr_en, wr_data, ovf_clr, i_ready,
                  input full, empty, level, overflow, o_data, o_valid);
  modport slave  (input wr_en, wr_data, ovf_clr, i_ready,
                  output full, empty, level, overflow, o_data, o_valid);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO from CPU IO writes to the UART emitter.
// Defining UART_TX_FIFO_IRQ_EN adds a registered low-water irq output (level <= THRESH).
module uart_tx_fifo #(
  parameter int DEPTH = 16
`ifdef UART_TX_FIFO_IRQ_EN
  , parameter int THRESH = 4
`endif
) (
  input  logic clk,
  input  logic resetn,
`ifdef UART_TX_FIFO_IRQ_EN
  output logic irq,
`endif
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, push, pop, drop;
  // Status comes only from the registered level, so full never sees a same-cycle pop.
  assign bus.full     = level_q == (AW+1)'(DEPTH);
  assign bus.empty    = level_q == '0;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;
  assign bus.o_valid  = !bus.empty;
  assign bus.o_data   = mem_q[rd_ptr_q];
  assign push = bus.wr_en && !bus.full;
  assign drop = bus.wr_en && bus.full;
  assign pop  = bus.o_valid && bus.i_ready;
  always_comb begin
    level_d = push && !pop ? level_q + (AW+1)'(1) : !push && pop ? level_q - (AW+1)'(1) : level_q;
    ovf_d   = drop ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end
`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_q <= 1'b1;
    else irq_q <= level_d <= (AW+1)'(THRESH);
  end
  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo; expected bytes queued on accepted pushes, compared on pops.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  logic ovf_m = 1'b0;
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();
`ifdef UART_TX_FIFO_IRQ_EN
  logic irq;
  uart_tx_fifo #(.DEPTH(DEPTH), .THRESH(4)) dut (.clk(clk), .resetn(resetn), .irq(irq), .bus(bus.slave));
`else
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
`endif
  always #5 clk = ~clk;

  // One clock of stimulus; the scoreboard compares every byte the emitter accepts.
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic was_full;
    bus.wr_en = w; bus.wr_data = d; bus.i_ready = r; bus.ovf_clr = c;
    was_full = sb.size() == DEPTH;
    if (r && sb.size() > 0) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== sb[0]) begin
        errors++;
        $display("FAIL pop_data: got valid=%b data=%h, expected valid=1 data=%h", bus.o_valid, bus.o_data, sb[0]);
      end
      void'(sb.pop_front());
    end
    if (w && !was_full) sb.push_back(d);
    if (w && was_full) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.i_ready = 1'b0; bus.ovf_clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 4 * DEPTH) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b level=%0d, expected empty=1 level=0", bus.empty, bus.level);
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.i_ready = 1'b0; bus.ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.level !== 5'd0 || bus.o_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got empty=%b full=%b level=%0d valid=%b ovf=%b, expected 1 0 0 0 0",
               bus.empty, bus.full, bus.level, bus.o_valid, bus.overflow);
    end
`ifdef UART_TX_FIFO_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b expected 1", irq); end
`endif
    #3 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b1, 8'h42, 1'b0, 1'b0);
    drive(1'b1, 8'h43, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd3 || bus.o_valid !== 1'b1 || bus.o_data !== 8'h41) begin
      errors++;
      $display("FAIL basic_fill: got level=%0d valid=%b data=%h, expected 3 1 41", bus.level, bus.o_valid, bus.o_data);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.o_data !== 8'h41) begin errors++; $display("FAIL basic_hold: got %h expected 41", bus.o_data); end
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL basic_empty: got empty=%b level=%0d, expected 1 0", bus.empty, bus.level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: got full=%b level=%0d ovf=%b, expected 1 16 1", bus.full, bus.level, bus.overflow);
    end
    drain();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== ovf_m) begin errors++; $display("FAIL ovf_clear: got %b expected %b", bus.overflow, ovf_m); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'h15 + 8'(i), 1'b1, 1'b0);
      checks++;
      if (bus.level !== 5'd5) begin errors++; $display("FAIL b2b_level: cycle %0d got %0d expected 5", i, bus.level); end
    end
    drain();
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd15) begin
      errors++;
      $display("FAIL drop_pop: got ovf=%b level=%0d, expected 1 15", bus.overflow, bus.level);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'hF0, 1'b0, 1'b0);
    drive(1'b1, 8'hEF, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_clr_prio: got %b expected 1", bus.overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL drop_clr: got %b expected 0", bus.overflow); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.level !== 5'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b level=%0d ovf=%b, expected 0 0 0", bus.o_valid, bus.level, bus.overflow);
    end
    sb.delete();
    ovf_m = 1'b0;
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h55) begin
      errors++;
      $display("FAIL post_reset_push: got valid=%b data=%h, expected 1 55", bus.o_valid, bus.o_data);
    end
    drain();
  endtask

`ifdef UART_TX_FIFO_IRQ_EN
  task automatic test_irq();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_thresh: got %b expected 1", irq); end
    drive(1'b1, 8'h64, 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_above: got %b expected 0", irq); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_pop: got %b expected 1", irq); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_full_drop();
    test_async_reset();
`ifdef UART_TX_FIFO_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
